// File: rtl/spi_mem_if.sv
// Request/response and pin bundle between the core-side requester and spi_mem_port.
// The requester owns start/request fields and sees the pins, so the bench can model the device.
interface spi_mem_if #(
    parameter int NUM_CS    = 2,
    parameter int MAX_BYTES = 4
);
    logic                     start;
    logic                     is_write;
    logic [2:0]               num_bytes;
    logic [31:0]              addr;
    logic [8*MAX_BYTES-1:0]   wdata;
    logic [8*MAX_BYTES-1:0]   rdata;
    logic                     busy;
    logic                     done;
    logic                     err;
    logic                     sclk;
    logic                     mosi;
    logic                     miso;
    logic [NUM_CS-1:0]        cs_n;

    modport master (
        output start, is_write, num_bytes, addr, wdata, miso,
        input  rdata, busy, done, err, sclk, mosi, cs_n
    );

    modport slave (
        input  start, is_write, num_bytes, addr, wdata, miso,
        output rdata, busy, done, err, sclk, mosi, cs_n
    );
endinterface

// File: rtl/spi_mem_port.sv
// SPI mode-0 memory port: command byte, device address, then 1..MAX_BYTES data bytes
// to one of NUM_CS devices, with a programmable SCLK half-period and request rejection.
//
//   state   | meaning
//   IDLE    | waiting for start; validates and latches the request
//   SHIFT   | frame on the pins; each bit is a low half then a high half of sclk
//   GUARD   | all selects released for one cycle; read data assembled
//   DONE    | one-cycle done pulse (err set if the request was rejected)
module spi_mem_port #(
    parameter int NUM_CS    = 2,
    parameter int ADDR_BITS = 24,
    parameter int MAX_BYTES = 4,
    parameter int CLK_DIV   = 1
) (
    input  logic       clk,
    input  logic       rst,
    spi_mem_if.slave   bus
);
    localparam int DW  = 8 * MAX_BYTES;
    localparam int FW  = 8 + ADDR_BITS + DW;
    localparam int BCW = $clog2(FW + 1);
    localparam int DCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GUARD = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0]     MAXB     = 3'(MAX_BYTES);
    localparam logic [31:0]    NCS      = 32'(NUM_CS);
    localparam logic [DCW-1:0] DIV_LOAD = DCW'(CLK_DIV - 1);

    logic [1:0]        state_q, state_d;
    logic [DCW-1:0]    div_q, div_d;
    logic [BCW-1:0]    bits_q, bits_d;
    logic [FW-1:0]     tx_q, tx_d;
    logic [DW-1:0]     rx_q, rx_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [2:0]        nb_q, nb_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic              sclk_q, sclk_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;

    // Every address bit above the device field counts toward the index, so a
    // stray high bit is rejected rather than aliased onto a real device.
    logic [31:0]    dev_idx;
    logic [CSW-1:0] cs_idx;
    logic           req_bad;
    logic [DW-1:0]  data_be;
    logic [FW-1:0]  frame_load;
    logic [BCW-1:0] nbits_load;
    logic           in_data;
    logic [DW-1:0]  rdata_asm;

    assign dev_idx = bus.addr >> ADDR_BITS;
    assign cs_idx  = bus.addr[ADDR_BITS +: CSW];
    assign req_bad = (bus.num_bytes == 3'd0) || (bus.num_bytes > MAXB) || (dev_idx >= NCS);

    always_comb begin
        data_be = '0;
        for (int k = 0; k < MAX_BYTES; k++) begin
            data_be[DW-1-8*k -: 8] = bus.wdata[8*k +: 8];
        end
    end

    assign frame_load = {(bus.is_write ? 8'h02 : 8'h03), bus.addr[ADDR_BITS-1:0], data_be};
    assign nbits_load = BCW'(8 + ADDR_BITS) + BCW'({bus.num_bytes, 3'b000});
    assign in_data    = (bits_q <= BCW'({nb_q, 3'b000}));

    // The first received byte ends up highest in rx_q; flip to little-endian.
    always_comb begin
        rdata_asm = '0;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (k < int'(nb_q)) begin
                rdata_asm[8*k +: 8] = rx_q[8*(int'(nb_q)-1-k) +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bits_d  = bits_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rdata_d = rdata_q;
        nb_d    = nb_q;
        wr_d    = wr_q;
        err_d   = err_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    wr_d  = bus.is_write;
                    nb_d  = bus.num_bytes;
                    err_d = req_bad;
                    if (req_bad) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                        tx_d    = frame_load;
                        bits_d  = nbits_load;
                        div_d   = DIV_LOAD;
                        sclk_d  = 1'b0;
                        rx_d    = '0;
                        cs_n_d  = ~(NUM_CS'(1) << cs_idx);
                    end
                end
            end
            S_SHIFT: begin
                if (div_q != '0) begin
                    div_d = div_q - DCW'(1);
                end else begin
                    div_d = DIV_LOAD;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        if (!wr_q && in_data) begin
                            rx_d = {rx_q[DW-2:0], bus.miso};
                        end
                    end else begin
                        // Falling edge: mosi advances, so it only ever moves while sclk is low.
                        sclk_d = 1'b0;
                        tx_d   = tx_q << 1;
                        if (bits_q == BCW'(1)) begin
                            state_d = S_GUARD;
                            cs_n_d  = '1;
                        end else begin
                            bits_d = bits_q - BCW'(1);
                        end
                    end
                end
            end
            S_GUARD: begin
                state_d = S_DONE;
                if (!wr_q && !err_q) begin
                    rdata_d = rdata_asm;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bits_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            nb_q    <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            sclk_q  <= 1'b0;
            cs_n_q  <= '1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bits_q  <= bits_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            nb_q    <= nb_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
        end
    end

    assign bus.sclk  = sclk_q;
    assign bus.cs_n  = cs_n_q;
    assign bus.mosi  = (state_q == S_SHIFT) && tx_q[FW-1];
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.done  = (state_q == S_DONE);
    assign bus.err   = (state_q == S_DONE) && err_q;
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_spi_mem_port.sv
// Directed bench: two ports (CLK_DIV 1 and 3), each with a small SPI device model
// that records mosi on rising sclk and serves miso from a preset frame.
module tb_spi_mem_port;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_mem_if #(.NUM_CS(2), .MAX_BYTES(4)) b1 ();
    spi_mem_if #(.NUM_CS(2), .MAX_BYTES(4)) b3 ();

    spi_mem_port #(.NUM_CS(2), .ADDR_BITS(24), .MAX_BYTES(4), .CLK_DIV(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    spi_mem_port #(.NUM_CS(2), .ADDR_BITS(24), .MAX_BYTES(4), .CLK_DIV(3)) u_div3 (
        .clk (clk),
        .rst (rst),
        .bus (b3.slave)
    );

    // Device models
    logic [71:0] miso_frame1, miso_frame3;
    logic [71:0] mosi_rec1, mosi_rec3;
    int rx_cnt1 = 0, rx_cnt3 = 0;
    int rises1 = 0, rises3 = 0;
    int cs0_f1 = 0, cs1_f1 = 0, cs_f3 = 0;
    wire sel_any1 = &b1.cs_n;
    wire sel_any3 = &b3.cs_n;

    always @(negedge sel_any1) begin rx_cnt1 = 0; mosi_rec1 = '0; end
    always @(negedge sel_any3) begin rx_cnt3 = 0; mosi_rec3 = '0; cs_f3++; end
    always @(negedge b1.cs_n[0]) cs0_f1++;
    always @(negedge b1.cs_n[1]) cs1_f1++;
    always @(posedge b1.sclk) begin mosi_rec1 = {mosi_rec1[70:0], b1.mosi}; rx_cnt1++; rises1++; end
    always @(posedge b3.sclk) begin mosi_rec3 = {mosi_rec3[70:0], b3.mosi}; rx_cnt3++; rises3++; end
    assign b1.miso = (rx_cnt1 < 72) ? miso_frame1[71 - rx_cnt1] : 1'b0;
    assign b3.miso = (rx_cnt3 < 72) ? miso_frame3[71 - rx_cnt3] : 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request on port 1; cyc = cycles from accept edge to done, errv = err at done.
    task automatic go1(input logic wr, input logic [2:0] nb, input logic [31:0] a,
                       input logic [31:0] wd, output int cyc, output logic errv);
        @(negedge clk);
        b1.start = 1'b1; b1.is_write = wr; b1.num_bytes = nb; b1.addr = a; b1.wdata = wd;
        @(posedge clk); #1;
        b1.start = 1'b0;
        cyc = 0;
        while (b1.done !== 1'b1 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
        end
        errv = b1.err;
        @(posedge clk); #1;
    endtask

    int cyc, c0, c1, r1, run, bad_runs;
    logic e, prev;

    initial begin
        rst = 1'b0;
        b1.start = 0; b1.is_write = 0; b1.num_bytes = 0; b1.addr = 0; b1.wdata = 0;
        b3.start = 0; b3.is_write = 0; b3.num_bytes = 0; b3.addr = 0; b3.wdata = 0;
        miso_frame1 = '0; miso_frame3 = '0;
        #1 rst = 1'b1;
        #1;
        chk("reset_pins", {b1.cs_n, b1.sclk, b1.mosi, b1.busy, b1.done, b1.err}, 7'b1100000);
        chk("reset_rdata", b1.rdata, 32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // 4-byte read from CS0
        miso_frame1 = {32'h0, 8'h13, 8'h05, 8'h10, 8'h00, 8'h00};
        c0 = cs0_f1; c1 = cs1_f1; r1 = rises1;
        go1(1'b0, 3'd4, 32'h0000_0000, 32'h0, cyc, e);
        chk("rd4_latency", cyc, 129);
        chk("rd4_err", e, 1'b0);
        chk("rd4_rdata", b1.rdata, 32'h0010_0513);
        chk("rd4_mosi", mosi_rec1[63:0], 64'h0300_0000_0000_0000);
        chk("rd4_rises", rises1 - r1, 64);
        chk("rd4_cs0_sel", cs0_f1 - c0, 1);
        chk("rd4_cs1_idle", cs1_f1 - c1, 0);

        // 2-byte read from CS1
        miso_frame1 = {32'h0, 8'hBE, 8'hEF, 24'h0};
        c0 = cs0_f1; c1 = cs1_f1;
        go1(1'b0, 3'd2, 32'h0100_0010, 32'h0, cyc, e);
        chk("rd2_latency", cyc, 97);
        chk("rd2_rdata", b1.rdata, 32'h0000_EFBE);
        chk("rd2_mosi", mosi_rec1[47:0], 48'h03_000010_0000);
        chk("rd2_cs1_sel", cs1_f1 - c1, 1);
        chk("rd2_cs0_idle", cs0_f1 - c0, 0);

        // Rejected requests: zero length, bad device index, oversize length
        c0 = cs0_f1; c1 = cs1_f1; r1 = rises1;
        go1(1'b0, 3'd0, 32'h0000_0000, 32'h0, cyc, e);
        chk("err_nb0_latency", cyc, 0);
        chk("err_nb0_err", e, 1'b1);
        go1(1'b0, 3'd2, 32'h0200_0000, 32'h0, cyc, e);
        chk("err_dev_latency", cyc, 0);
        chk("err_dev_err", e, 1'b1);
        go1(1'b1, 3'd5, 32'h0000_0000, 32'h0, cyc, e);
        chk("err_nb5_err", e, 1'b1);
        chk("err_no_cs", (cs0_f1 - c0) + (cs1_f1 - c1), 0);
        chk("err_no_sclk", rises1 - r1, 0);
        chk("err_rdata_kept", b1.rdata, 32'h0000_EFBE);

        // Asynchronous reset in the middle of the data phase
        miso_frame1 = {32'h0, 8'h13, 8'h05, 8'h10, 8'h00, 8'h00};
        @(negedge clk);
        b1.start = 1'b1; b1.is_write = 1'b0; b1.num_bytes = 3'd4; b1.addr = 32'h0; b1.wdata = 32'h0;
        @(posedge clk); #1;
        b1.start = 1'b0;
        repeat (80) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_pins", {b1.cs_n, b1.sclk, b1.busy, b1.done}, 5'b11000);
        chk("rst_mid_rdata", b1.rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_no_done", {b1.done, b1.busy}, 2'b00);

        go1(1'b0, 3'd4, 32'h0000_0000, 32'h0, cyc, e);
        chk("post_rst_latency", cyc, 129);
        chk("post_rst_rdata", b1.rdata, 32'h0010_0513);

        // 1-byte write
        miso_frame1 = {72{1'b1}};
        r1 = rises1;
        go1(1'b1, 3'd1, 32'h0000_0104, 32'h0000_00A5, cyc, e);
        chk("wr1_latency", cyc, 81);
        chk("wr1_err", e, 1'b0);
        chk("wr1_mosi", mosi_rec1[39:0], 40'h02_000104_A5);
        chk("wr1_rises", rises1 - r1, 40);
        chk("wr1_rdata_kept", b1.rdata, 32'h0010_0513);

        // CLK_DIV=3 read with start held high while busy
        miso_frame3 = {32'h0, 8'h5A, 32'h0};
        c0 = cs_f3; r1 = rises3;
        @(negedge clk);
        b3.start = 1'b1; b3.is_write = 1'b0; b3.num_bytes = 3'd1; b3.addr = 32'h0000_0020; b3.wdata = 32'h0;
        @(posedge clk); #1;
        cyc = 0; prev = b3.sclk; run = 1; bad_runs = 0;
        while (b3.done !== 1'b1 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (b3.sclk !== prev) begin
                if (run != 3) bad_runs++;
                run = 1;
                prev = b3.sclk;
            end else begin
                run++;
            end
        end
        b3.start = 1'b0;
        chk("div3_latency", cyc, 241);
        chk("div3_half_periods", bad_runs, 0);
        chk("div3_rises", rises3 - r1, 40);
        chk("div3_rdata", b3.rdata, 32'h0000_005A);
        chk("div3_mosi", mosi_rec3[39:0], 40'h03_000020_00);
        repeat (5) @(posedge clk);
        #1;
        chk("div3_single_frame", cs_f3 - c0, 1);
        chk("div3_idle_after", {b3.cs_n, b3.busy}, 3'b110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
